// File: rtl/riscv_ctrl_pkg.sv
// Shared control constants for the multicycle RV32I core: opcodes, FSM states,
// datapath select encodings and the per-cycle control word.
package riscv_ctrl_pkg;

    localparam int unsigned OP_W    = 7;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned SEL_W   = 2;

    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_RDATA  = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic             pc_write;
        logic             adr_src;
        logic             mem_write;
        logic             ir_write;
        logic             reg_write;
        logic [SEL_W-1:0] result_src;
        logic [SEL_W-1:0] alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic [SEL_W-1:0] imm_src;
        logic             instr_done;
    } ctrl_word_t;

    // Immediate format follows the opcode alone; R-type has no immediate so it takes I.
    function automatic logic [SEL_W-1:0] imm_sel(input logic [OP_W-1:0] op);
        case (op)
            OP_SW:   imm_sel = IMM_S;
            OP_BEQ:  imm_sel = IMM_B;
            OP_JAL:  imm_sel = IMM_J;
            default: imm_sel = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath bundle: IR opcode, ALU flag, memory handshake in; control word out.
interface multicycle_control_fsm_if;
    import riscv_ctrl_pkg::*;

    logic [OP_W-1:0]    op;
    logic               zero;
    logic               mem_ready;
    logic               pc_write;
    logic               adr_src;
    logic               mem_write;
    logic               ir_write;
    logic               reg_write;
    logic [SEL_W-1:0]   result_src;
    logic [SEL_W-1:0]   alu_src_a;
    logic [SEL_W-1:0]   alu_src_b;
    logic [SEL_W-1:0]   alu_op;
    logic [SEL_W-1:0]   imm_src;
    logic               instr_done;
    logic               illegal_op;
    logic [STATE_W-1:0] state;

    modport master (
        input  op, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, instr_done, illegal_op, state
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, instr_done, illegal_op, state
    );
endinterface

// File: rtl/mc_control_word_decoder.sv
// Pure combinational mapping from FSM state plus op/zero/mem_ready to the datapath control word.
module mc_control_word_decoder
    import riscv_ctrl_pkg::*;
(
    input  state_t          i_state,
    input  logic [OP_W-1:0] i_op,
    input  logic            i_zero,
    input  logic            i_mem_ready,
    output ctrl_word_t      o_cw_c
);

    always_comb begin
        o_cw_c         = '0;
        o_cw_c.imm_src = imm_sel(i_op);
        case (i_state)
            S_FETCH: begin
                o_cw_c.alu_src_a  = SRCA_PC;
                o_cw_c.alu_src_b  = SRCB_FOUR;
                o_cw_c.alu_op     = ALUOP_ADD;
                o_cw_c.result_src = RES_ALU;
                o_cw_c.ir_write   = i_mem_ready;
                o_cw_c.pc_write   = i_mem_ready;
            end
            S_DECODE: begin
                o_cw_c.alu_src_a = SRCA_OLDPC;
                o_cw_c.alu_src_b = SRCB_IMM;
                o_cw_c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_EXECI: begin
                o_cw_c.alu_src_a = SRCA_RS1;
                o_cw_c.alu_src_b = SRCB_IMM;
                o_cw_c.alu_op    = (i_state == S_EXECI) ? ALUOP_FUNCT : ALUOP_ADD;
            end
            S_MEMREAD: begin
                o_cw_c.adr_src    = 1'b1;
                o_cw_c.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                o_cw_c.result_src = RES_RDATA;
                o_cw_c.reg_write  = 1'b1;
                o_cw_c.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                o_cw_c.adr_src    = 1'b1;
                o_cw_c.mem_write  = 1'b1;
                o_cw_c.instr_done = i_mem_ready;
            end
            S_EXECR: begin
                o_cw_c.alu_src_a = SRCA_RS1;
                o_cw_c.alu_src_b = SRCB_RS2;
                o_cw_c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_cw_c.result_src = RES_ALUOUT;
                o_cw_c.reg_write  = 1'b1;
                o_cw_c.instr_done = 1'b1;
            end
            S_JAL: begin
                o_cw_c.alu_src_a  = SRCA_OLDPC;
                o_cw_c.alu_src_b  = SRCB_FOUR;
                o_cw_c.alu_op     = ALUOP_ADD;
                o_cw_c.result_src = RES_ALUOUT;
                o_cw_c.pc_write   = 1'b1;
            end
            S_BEQ: begin
                o_cw_c.alu_src_a  = SRCA_RS1;
                o_cw_c.alu_src_b  = SRCB_RS2;
                o_cw_c.alu_op     = ALUOP_SUB;
                o_cw_c.result_src = RES_ALUOUT;
                o_cw_c.pc_write   = i_zero;
                o_cw_c.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main multicycle RV32I control FSM: state register, next-state logic and sticky illegal-op flag.
// The control word itself comes from mc_control_word_decoder; write enables are masked in reset.
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter logic [STATE_W-1:0] RESET_STATE = 4'd0
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_fsm_if.master  ctl_if
);

    state_t     r_state;
    state_t     w_next;
    logic       r_illegal;
    ctrl_word_t w_cw;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= state_t'(RESET_STATE);
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_ILLEGAL) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    w_next = ctl_if.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (ctl_if.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = S_ILLEGAL;
                endcase
            end
            // IR cannot change outside FETCH, so only lw/sw can reach here.
            S_MEMADR: begin
                case (ctl_if.op)
                    OP_LW:   w_next = S_MEMREAD;
                    OP_SW:   w_next = S_MEMWRITE;
                    default: w_next = S_ILLEGAL;
                endcase
            end
            S_MEMREAD:  w_next = ctl_if.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = ctl_if.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_EXECI:    w_next = S_ALUWB;
            S_JAL:      w_next = S_ALUWB;
            S_BEQ:      w_next = S_FETCH;
            S_ILLEGAL:  w_next = S_ILLEGAL;
            default:    w_next = S_ILLEGAL;
        endcase
    end

    mc_control_word_decoder u_cw_dec (
        .i_state     (r_state),
        .i_op        (ctl_if.op),
        .i_zero      (ctl_if.zero),
        .i_mem_ready (ctl_if.mem_ready),
        .o_cw_c      (w_cw)
    );

    assign ctl_if.pc_write   = w_cw.pc_write   & ~reset;
    assign ctl_if.ir_write   = w_cw.ir_write   & ~reset;
    assign ctl_if.mem_write  = w_cw.mem_write  & ~reset;
    assign ctl_if.reg_write  = w_cw.reg_write  & ~reset;
    assign ctl_if.instr_done = w_cw.instr_done & ~reset;
    assign ctl_if.adr_src    = w_cw.adr_src;
    assign ctl_if.result_src = w_cw.result_src;
    assign ctl_if.alu_src_a  = w_cw.alu_src_a;
    assign ctl_if.alu_src_b  = w_cw.alu_src_b;
    assign ctl_if.alu_op     = w_cw.alu_op;
    assign ctl_if.imm_src    = w_cw.imm_src;
    assign ctl_if.illegal_op = r_illegal & ~reset;
    assign ctl_if.state      = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: each instruction is expanded into its list of
// states, mem_ready/zero are driven per cycle and every output is compared each cycle.
module tb_multicycle_control_fsm;

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_BEQ = 7'b1100011;
    localparam logic [6:0] T_JAL = 7'b1101111;
    localparam logic [6:0] T_BAD = 7'b0001111;

    logic clk = 1'b0;
    logic reset;

    multicycle_control_fsm_if ctl_if ();

    multicycle_control_fsm #(.RESET_STATE(4'd0)) dut (
        .clk    (clk),
        .reset  (reset),
        .ctl_if (ctl_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int q_st[$];
    bit q_wt[$];
    bit m_illegal;
    int fetch_stall;
    int mem_stall;
    bit cur_zero;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        case (o)
            T_SW:    return 2'd1;
            T_BEQ:   return 2'd2;
            T_JAL:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // {adr_src, result_src, alu_src_a, alu_src_b, alu_op, imm_src}
    function automatic logic [10:0] exp_mux(input int s, input logic [6:0] o);
        logic       adr;
        logic [1:0] res, a, b, aop;
        adr = (s == 3 || s == 5);
        res = (s == 0) ? 2'd2 : (s == 4) ? 2'd1 : 2'd0;
        case (s)
            1, 9:          a = 2'd1;
            2, 6, 8, 10:   a = 2'd2;
            default:       a = 2'd0;
        endcase
        case (s)
            0, 9:          b = 2'd2;
            1, 2, 8:       b = 2'd1;
            default:       b = 2'd0;
        endcase
        case (s)
            6, 8:          aop = 2'd2;
            10:            aop = 2'd1;
            default:       aop = 2'd0;
        endcase
        return {adr, res, a, b, aop, exp_imm(o)};
    endfunction

    function automatic logic [5:0] got_en();
        return {ctl_if.pc_write, ctl_if.ir_write, ctl_if.mem_write,
                ctl_if.reg_write, ctl_if.instr_done, ctl_if.illegal_op};
    endfunction

    function automatic logic [10:0] got_mux();
        return {ctl_if.adr_src, ctl_if.result_src, ctl_if.alu_src_a,
                ctl_if.alu_src_b, ctl_if.alu_op, ctl_if.imm_src};
    endfunction

    // State sequence of one instruction; the flag marks states that wait on mem_ready.
    task automatic build(input logic [6:0] o);
        q_st.delete();
        q_wt.delete();
        q_st.push_back(0); q_wt.push_back(1'b1);
        q_st.push_back(1); q_wt.push_back(1'b0);
        case (o)
            T_LW:  begin q_st.push_back(2); q_wt.push_back(1'b0);
                         q_st.push_back(3); q_wt.push_back(1'b1);
                         q_st.push_back(4); q_wt.push_back(1'b0); end
            T_SW:  begin q_st.push_back(2); q_wt.push_back(1'b0);
                         q_st.push_back(5); q_wt.push_back(1'b1); end
            T_R:   begin q_st.push_back(6); q_wt.push_back(1'b0);
                         q_st.push_back(7); q_wt.push_back(1'b0); end
            T_I:   begin q_st.push_back(8); q_wt.push_back(1'b0);
                         q_st.push_back(7); q_wt.push_back(1'b0); end
            T_BEQ: begin q_st.push_back(10); q_wt.push_back(1'b0); end
            T_JAL: begin q_st.push_back(9); q_wt.push_back(1'b0);
                         q_st.push_back(7); q_wt.push_back(1'b0); end
            default: begin q_st.push_back(11); q_wt.push_back(1'b0); end
        endcase
    endtask

    task automatic tick(input logic [6:0] o);
        int         s;
        bit         mr;
        bit         adv;
        bit         done_now;
        logic [5:0] en_exp;
        s = q_st[0];
        if (q_wt[0]) begin
            if (s == 0) begin
                mr = (fetch_stall == 0);
                if (fetch_stall > 0) fetch_stall--;
            end else begin
                mr = (mem_stall == 0);
                if (mem_stall > 0) mem_stall--;
            end
        end else begin
            mr = 1'($urandom_range(0, 1));
        end
        ctl_if.op        = o;
        ctl_if.mem_ready = mr;
        ctl_if.zero      = cur_zero;
        adv      = (s != 11) && (!q_wt[0] || mr);
        done_now = adv && (q_st.size() == 1);
        en_exp   = {((s == 0) && mr) || (s == 9) || ((s == 10) && cur_zero),
                    (s == 0) && mr, s == 5, (s == 4) || (s == 7), done_now, m_illegal};
        @(negedge clk);
        chk($sformatf("state s%0d", s), 32'(ctl_if.state), 32'(s));
        chk($sformatf("enables s%0d mr%0d z%0d", s, mr, cur_zero), 32'(got_en()), 32'(en_exp));
        chk($sformatf("muxes s%0d op%b", s, o), 32'(got_mux()), 32'(exp_mux(s, o)));
        @(posedge clk);
        #1;
        if (adv) begin
            void'(q_st.pop_front());
            void'(q_wt.pop_front());
        end
        if (q_st.size() > 0 && q_st[0] == 11) m_illegal = 1'b1;
    endtask

    // Runs one instruction; stops early when abort_state is reached or after 20 ILLEGAL cycles.
    task automatic run_instr(input logic [6:0] o, input int fs, input int ms, input bit z,
                             input int abort_state);
        int ill_cycles;
        ill_cycles  = 0;
        build(o);
        fetch_stall = fs;
        mem_stall   = ms;
        cur_zero    = z;
        while (q_st.size() > 0) begin
            if (q_st[0] == abort_state) break;
            if (q_st[0] == 11) begin
                if (ill_cycles == 20) break;
                ill_cycles++;
            end
            tick(o);
        end
    endtask

    // Two reset cycles with mem_ready/zero high: every enable and the sticky flag must read 0.
    task automatic do_reset();
        reset            = 1'b1;
        ctl_if.mem_ready = 1'b1;
        ctl_if.zero      = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("reset enables c%0d", i), 32'(got_en()), 32'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        q_st.delete();
        q_wt.delete();
        m_illegal = 1'b0;
    endtask

    logic [6:0] legal_ops [6];

    initial begin
        legal_ops = '{T_LW, T_SW, T_R, T_I, T_BEQ, T_JAL};
        reset            = 1'b1;
        ctl_if.op        = 7'd0;
        ctl_if.zero      = 1'b0;
        ctl_if.mem_ready = 1'b0;
        m_illegal        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        run_instr(T_LW,  0, 0, 1'b0, -1);
        run_instr(T_SW,  1, 2, 1'b0, -1);
        run_instr(T_BEQ, 0, 0, 1'b1, -1);
        run_instr(T_BEQ, 0, 0, 1'b0, -1);
        run_instr(T_JAL, 0, 0, 1'b0, -1);
        run_instr(T_R,   2, 0, 1'b1, -1);
        run_instr(T_I,   0, 0, 1'b0, -1);
        run_instr(T_BAD, 0, 0, 1'b0, -1);
        do_reset();
        run_instr(T_LW,  0, 3, 1'b0, 3);
        do_reset();

        for (int n = 0; n < 60; n++) begin
            run_instr(legal_ops[$urandom_range(0, 5)], int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), -1);
        end
        run_instr(7'($urandom_range(0, 127)) | 7'b0000100, 0, 0, 1'b0, -1);
        do_reset();
        run_instr(T_SW, 0, 0, 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
